uart_word_sender: RTL and testbench

Client-side transmit controller that sits in front of the UART block's transmit interface inside the DebugUnit. It accepts one DATA_WIDTH-bit word and sends it as consecutive UART_BITS-bit bytes, least-significant byte first. It issues one tx-start pulse per byte and waits for the UART's tx-done pulse before issuing the next. It reports busy while sending and pulses done after the final byte completes. The debug unit uses it to stream PC, register and memory words to the host.

---
 rtl/uart_word_sender.sv | 87 ++++++++
 tb/tb_uart_word_sender.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_sender.sv
// uart_word_sender
//   Splits one DATA_WIDTH-bit word into UART_BITS-bit bytes and hands them to
//   the UART transmitter least-significant byte first. One o_tx_start pulse is
//   issued per byte. The next byte is not started until the UART returns
//   i_tx_done for the current one. o_done pulses once after the last byte.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   i_start     request to send i_data (only honoured when idle)
//   i_data      word to send, captured when i_start is accepted
//   i_tx_done   UART pulse: current byte frame finished
//   o_tx_start  pulse to UART: start sending o_tx_data
//   o_tx_data   byte being sent, held until the matching i_tx_done
//   o_busy      high while a word is in progress
//   o_done      one-cycle pulse after the final byte completes
module uart_word_sender #(
  parameter int DATA_WIDTH = 32,
  parameter int UART_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [UART_BITS-1:0]  o_tx_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NBYTES = DATA_WIDTH / UART_BITS;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic                  done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            shift_q <= i_data;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: state_q <= WAIT;
        WAIT: begin
          if (i_tx_done) begin
            if (cnt_q == LAST_BYTE) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              // Next byte moves into the low lane; the upper lane fills with zeros.
              shift_q <= shift_q >> UART_BITS;
              cnt_q   <= cnt_q + CW'(1);
              state_q <= SEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_data  = shift_q[UART_BITS-1:0];
  assign o_tx_start = (state_q == SEND);
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;

endmodule

// File: tb/tb_uart_word_sender.sv
// Self-checking bench for uart_word_sender (32-bit and 8-bit instances).
module tb_uart_word_sender;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [31:0] i_data;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_done;

  logic        s8_start;
  logic [7:0]  s8_data;
  logic        s8_tx_done;
  logic        s8_tx_start;
  logic [7:0]  s8_tx_data;
  logic        s8_busy;
  logic        s8_done;

  int checks    = 0;
  int failures  = 0;
  int mon_starts = 0;
  int mon_dones  = 0;
  int mon8_starts = 0;
  int exp_starts = 0;
  int exp_dones  = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic [31:0] seq;     // expected bytes in send order, first byte in [31:24]
    int          intrude; // byte index during which a stray i_start is pulsed, -1 none
  } vec_t;

  vec_t tbl[3];

  uart_word_sender #(.DATA_WIDTH(32), .UART_BITS(8)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_data(i_data),
    .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  uart_word_sender #(.DATA_WIDTH(8), .UART_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .i_start(s8_start), .i_data(s8_data),
    .i_tx_done(s8_tx_done), .o_tx_start(s8_tx_start), .o_tx_data(s8_tx_data),
    .o_busy(s8_busy), .o_done(s8_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every start pulse pops one expected byte.
  always @(negedge clk) begin
    if (o_tx_start) begin
      mon_starts++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_tx_start: got byte %0h expected no start", o_tx_data);
      end else begin
        chk("tx_data", 32'(o_tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (o_done) mon_dones++;
    if (s8_tx_start) mon8_starts++;
  end

  task automatic start_word(input logic [31:0] data, input logic [31:0] seq);
    i_start = 1'b1;
    i_data  = data;
    for (int k = 0; k < 4; k++) exp_q.push_back(seq[31-8*k -: 8]);
    step();
    i_start = 1'b0;
    i_data  = $urandom();
  endtask

  // Called in a SEND cycle; returns in the cycle after i_tx_done.
  task automatic serve_one(input int intrude);
    chk("start_latency", 32'(o_tx_start), 32'd1);
    chk("busy_send", 32'(o_busy), 32'd1);
    exp_starts++;
    step();
    for (int k = 1; k < 5; k++) begin
      if (intrude == 1 && k == 2) begin
        i_start = 1'b1;
        i_data  = 32'hAAAAAAAA;
      end
      step();
      i_start = 1'b0;
      chk("busy_wait", 32'(o_busy), 32'd1);
    end
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  // Returns positioned in the o_done cycle.
  task automatic serve_bytes(input int nb, input int intrude_idx);
    for (int b = 0; b < nb; b++) serve_one((b == intrude_idx) ? 1 : 0);
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_at_done", 32'(o_busy), 32'd0);
    chk("no_start_at_done", 32'(o_tx_start), 32'd0);
    exp_dones++;
  endtask

  initial begin
    tbl[0] = '{data: 32'hDEADBEEF, seq: 32'hEFBEADDE, intrude: -1};
    tbl[1] = '{data: 32'h11223344, seq: 32'h44332211, intrude: 1};
    tbl[2] = '{data: 32'h80000001, seq: 32'h01000080, intrude: -1};

    rst = 1'b1; i_start = 1'b0; i_data = '0; i_tx_done = 1'b0;
    s8_start = 1'b0; s8_data = '0; s8_tx_done = 1'b0;
    step();
    step();
    chk("rst_tx_start", 32'(o_tx_start), 32'd0);
    chk("rst_tx_data", 32'(o_tx_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    step();

    // Table-driven words
    for (int v = 0; v < 3; v++) begin
      start_word(tbl[v].data, tbl[v].seq);
      serve_bytes(4, tbl[v].intrude);
      step();
      chk("done_one_cycle", 32'(o_done), 32'd0);
      repeat (3) step();
      chk("idle_after_word", 32'(o_busy), 32'd0);
    end

    // Back-to-back: new start in the o_done cycle
    start_word(32'hCAFEF00D, 32'h0DF0FECA);
    serve_bytes(4, -1);
    start_word(32'h01020304, 32'h04030201);
    serve_bytes(4, -1);
    step();
    chk("b2b_done_clear", 32'(o_done), 32'd0);

    // Spurious done in IDLE and in SEND
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    chk("spur_idle_busy", 32'(o_busy), 32'd0);
    chk("spur_idle_start", 32'(o_tx_start), 32'd0);
    start_word(32'h12345678, 32'h78563412);
    chk("spur_send_start", 32'(o_tx_start), 32'd1);
    exp_starts++;
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("spur_hold_start", 32'(o_tx_start), 32'd0);
      chk("spur_hold_busy", 32'(o_busy), 32'd1);
      step();
    end
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    serve_bytes(3, -1);
    step();

    // Reset in the middle of a word
    start_word(32'h55667788, 32'h88776655);
    serve_one(0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_tx_start", 32'(o_tx_start), 32'd0);
    chk("arst_tx_data", 32'(o_tx_data), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_done", 32'(o_done), 32'd0);
    step();
    step();
    chk("arst_hold_done", 32'(o_done), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_start", 32'(o_tx_start), 32'd0);
    start_word(32'h0000ABCD, 32'hCDAB0000);
    serve_bytes(4, -1);
    step();

    // Single-byte instance
    s8_start = 1'b1;
    s8_data  = 8'h5A;
    step();
    s8_start = 1'b0;
    s8_data  = 8'hFF;
    chk("w8_start", 32'(s8_tx_start), 32'd1);
    chk("w8_data", 32'(s8_tx_data), 32'h5A);
    step();
    chk("w8_wait_start", 32'(s8_tx_start), 32'd0);
    chk("w8_wait_busy", 32'(s8_busy), 32'd1);
    step();
    s8_tx_done = 1'b1;
    step();
    s8_tx_done = 1'b0;
    chk("w8_done", 32'(s8_done), 32'd1);
    chk("w8_busy_done", 32'(s8_busy), 32'd0);
    step();
    chk("w8_done_clear", 32'(s8_done), 32'd0);

    repeat (4) step();
    chk("start_count", 32'(mon_starts), 32'(exp_starts));
    chk("done_count", 32'(mon_dones), 32'(exp_dones));
    chk("w8_start_count", 32'(mon8_starts), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
